// File: rtl/bp_stream_host.sv
// Host-side endpoint for the BedRock MMIO word stream: decodes (address, data)
// pairs into console TX/RX, finish and cycle-counter accesses.
module bp_stream_host #(
    parameter int          stream_data_width_p = 32,
    parameter logic [31:0] putchar_addr_p      = 32'h0010_1000,
    parameter logic [31:0] getchar_addr_p      = 32'h0010_0000,
    parameter logic [31:0] finish_addr_p       = 32'h0010_2000,
    parameter logic [31:0] cycle_addr_p        = 32'h0010_3000,
    parameter int          tx_els_p            = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_yumi_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic                           tx_v_o,
    output logic [7:0]                     tx_data_o,
    input  logic                           tx_yumi_i,
    input  logic                           rx_v_i,
    input  logic [7:0]                     rx_data_i,
    output logic                           rx_ready_o,
    output logic                           finish_o,
    output logic [7:0]                     finish_code_o
);
    localparam int ptr_w = $clog2(tx_els_p);
    localparam logic [ptr_w:0] tx_full_cnt = tx_els_p[ptr_w:0];

    typedef enum logic [1:0] {ADDR, DATA, RESP_LO, RESP_HI} state_e;

    state_e                         state_q, state_d;
    logic [stream_data_width_p-1:0] addr_q, addr_d;
    logic [63:0]                    resp_q, resp_d;
    logic [63:0]                    cycle_q, cycle_d;
    logic [7:0]                     tx_mem_q [tx_els_p];
    logic [7:0]                     tx_mem_d [tx_els_p];
    logic [ptr_w-1:0]               tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [ptr_w:0]                 tx_cnt_q, tx_cnt_d;
    logic                           rx_full_q, rx_full_d;
    logic [7:0]                     rx_data_q, rx_data_d;
    logic                           finish_q, finish_d;
    logic [7:0]                     finish_code_q, finish_code_d;

    logic tx_push, tx_pop, tx_full, rx_pop, rx_load, fin_set;

    assign tx_full = (tx_cnt_q == tx_full_cnt);
    assign tx_pop  = tx_yumi_i & (tx_cnt_q != '0);
    assign rx_load = rx_v_i & ~rx_full_q;

    // Pair decode; response words come only from registered state.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        resp_d        = resp_q;
        stream_yumi_o = 1'b0;
        tx_push       = 1'b0;
        rx_pop        = 1'b0;
        fin_set       = 1'b0;
        case (state_q)
            ADDR: begin
                stream_yumi_o = stream_v_i;
                if (stream_v_i) begin
                    addr_d  = stream_data_i;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (addr_q == putchar_addr_p) begin
                    // A same-cycle pop frees the slot for this push.
                    stream_yumi_o = stream_v_i & (~tx_full | tx_pop);
                    tx_push       = stream_yumi_o;
                    if (stream_yumi_o) state_d = ADDR;
                end else begin
                    stream_yumi_o = stream_v_i;
                    if (stream_v_i) begin
                        if (addr_q == finish_addr_p) begin
                            fin_set = 1'b1;
                            state_d = ADDR;
                        end else if (addr_q == getchar_addr_p) begin
                            resp_d  = rx_full_q ? {56'b0, rx_data_q} : '1;
                            rx_pop  = rx_full_q;
                            state_d = RESP_LO;
                        end else if (addr_q == cycle_addr_p) begin
                            resp_d  = cycle_q;
                            state_d = RESP_LO;
                        end else begin
                            state_d = ADDR;
                        end
                    end
                end
            end
            RESP_LO: if (stream_ready_i) state_d = RESP_HI;
            RESP_HI: if (stream_ready_i) state_d = ADDR;
            default: state_d = ADDR;
        endcase
    end

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = stream_data_i[7:0];
            tx_wptr_d           = tx_wptr_q + 1'b1;
        end
        if (tx_pop) tx_rptr_d = tx_rptr_q + 1'b1;
        tx_cnt_d = tx_cnt_q + {{ptr_w{1'b0}}, tx_push} - {{ptr_w{1'b0}}, tx_pop};

        rx_full_d = rx_full_q;
        rx_data_d = rx_data_q;
        if (rx_pop) rx_full_d = 1'b0;
        if (rx_load) begin
            rx_full_d = 1'b1;
            rx_data_d = rx_data_i;
        end

        finish_d      = finish_q | fin_set;
        finish_code_d = (fin_set & ~finish_q) ? stream_data_i[7:0] : finish_code_q;
        cycle_d       = cycle_q + 64'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ADDR;
            addr_q        <= '0;
            resp_q        <= '0;
            cycle_q       <= '0;
            for (int i = 0; i < tx_els_p; i++) tx_mem_q[i] <= '0;
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            tx_cnt_q      <= '0;
            rx_full_q     <= 1'b0;
            rx_data_q     <= '0;
            finish_q      <= 1'b0;
            finish_code_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            resp_q        <= resp_d;
            cycle_q       <= cycle_d;
            tx_mem_q      <= tx_mem_d;
            tx_wptr_q     <= tx_wptr_d;
            tx_rptr_q     <= tx_rptr_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_full_q     <= rx_full_d;
            rx_data_q     <= rx_data_d;
            finish_q      <= finish_d;
            finish_code_q <= finish_code_d;
        end
    end

    assign stream_v_o    = (state_q == RESP_LO) | (state_q == RESP_HI);
    assign stream_data_o = (state_q == RESP_HI) ? resp_q[63:32] : resp_q[31:0];
    assign tx_v_o        = (tx_cnt_q != '0);
    assign tx_data_o     = tx_mem_q[tx_rptr_q];
    assign rx_ready_o    = ~rx_full_q;
    assign finish_o      = finish_q;
    assign finish_code_o = finish_code_q;
endmodule
